// File: rtl/pcs_tx_pkg.sv
// Shared constants and types for the 100GbE PCS transmit-side 64B/66B encoder.
// Holds MII characters, 7-bit block codes, block-type bytes, the T_TYPE and
// state enums, the fixed error/local-fault blocks and the terminate-type lookup.
package pcs_tx_pkg;

    localparam int unsigned LEN_CODED_BLOCK = 66;
    localparam int unsigned LEN_TX_DATA     = 64;
    localparam int unsigned LEN_TX_CTRL     = 8;
    localparam int unsigned LEN_ERR_CNT     = 16;

    // MII control characters
    localparam logic [7:0] MII_IDLE  = 8'h07;
    localparam logic [7:0] MII_START = 8'hFB;
    localparam logic [7:0] MII_TERM  = 8'hFD;
    localparam logic [7:0] MII_ERROR = 8'hFE;
    localparam logic [7:0] MII_SEQ   = 8'h9C;

    // 7-bit control codes inside a coded block
    localparam logic [6:0] CODE_IDLE  = 7'h00;
    localparam logic [6:0] CODE_ERROR = 7'h1E;

    // Sync headers
    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    // Block-type bytes
    localparam logic [7:0] BT_CTRL  = 8'h1E;
    localparam logic [7:0] BT_START = 8'h78;
    localparam logic [7:0] BT_OSET  = 8'h4B;

    localparam logic [LEN_CODED_BLOCK-1:0] EBLOCK_T = 66'h2_1E3C_78F1_E3C7_8F1E;
    localparam logic [LEN_CODED_BLOCK-1:0] LBLOCK_T = 66'h2_4B00_0001_0000_0000;

    typedef enum logic [2:0] {
        TypeC,
        TypeS,
        TypeD,
        TypeT,
        TypeE
    } t_type_e;

    typedef enum logic [2:0] {
        TxInit,
        TxC,
        TxD,
        TxT,
        TxE
    } tx_state_e;

    // Block-type byte for a terminate in lane k
    function automatic logic [7:0] term_block_type(input logic [2:0] lane);
        logic [7:0] bt;
        unique case (lane)
            3'd0:    bt = 8'h87;
            3'd1:    bt = 8'h99;
            3'd2:    bt = 8'hAA;
            3'd3:    bt = 8'hB4;
            3'd4:    bt = 8'hCC;
            3'd5:    bt = 8'hD2;
            3'd6:    bt = 8'hE1;
            default: bt = 8'hFF;
        endcase
        return bt;
    endfunction

endpackage

// File: rtl/tx_type_classifier.sv
// Combinational T_TYPE classifier for one 64-bit MII word.
// Ports:
//   tx_data     in  64  byte 0 (first on the wire) in [63:56]
//   tx_ctrl     in  8   bit 7 flags byte 0 as a control character
//   t_type      out     C / S / D / T / E classification
//   term_lane   out 3   lane holding Terminate (valid when t_type == TypeT)
//   ordered_set out 1   C-type word is an ordered set rather than idle/error
module tx_type_classifier
    import pcs_tx_pkg::*;
(
    input  logic [LEN_TX_DATA-1:0] tx_data,
    input  logic [LEN_TX_CTRL-1:0] tx_ctrl,
    output t_type_e                t_type,
    output logic [2:0]             term_lane,
    output logic                   ordered_set
);

    logic [7:0] lane [8];
    logic       all_idle_err;
    logic       oset_hit;
    logic       term_hit;
    logic [2:0] term_k;
    logic       tail_ok;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            lane[i] = tx_data[63 - 8*i -: 8];
        end

        all_idle_err = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (lane[i] != MII_IDLE && lane[i] != MII_ERROR) begin
                all_idle_err = 1'b0;
            end
        end

        oset_hit = (tx_ctrl == 8'h8F) && (lane[0] == MII_SEQ) && (lane[4] == MII_IDLE) &&
                   (lane[5] == MII_IDLE) && (lane[6] == MII_IDLE) && (lane[7] == MII_IDLE);

        // Terminate in lane k: ctrl bits for lanes >= k set, lanes < k clear,
        // and every lane after the terminate must be Idle.
        term_hit = 1'b0;
        term_k   = 3'd0;
        tail_ok  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tail_ok = 1'b1;
            for (int j = k + 1; j < 8; j++) begin
                if (lane[j] != MII_IDLE) begin
                    tail_ok = 1'b0;
                end
            end
            if ((tx_ctrl == (8'hFF >> k)) && (lane[k] == MII_TERM) && tail_ok) begin
                term_hit = 1'b1;
                term_k   = 3'(k);
            end
        end

        t_type      = TypeE;
        ordered_set = 1'b0;
        term_lane   = term_k;
        if (tx_ctrl == 8'h00) begin
            t_type = TypeD;
        end else if (tx_ctrl == 8'h80 && lane[0] == MII_START) begin
            t_type = TypeS;
        end else if (tx_ctrl == 8'hFF && all_idle_err) begin
            t_type = TypeC;
        end else if (oset_hit) begin
            t_type      = TypeC;
            ordered_set = 1'b1;
        end else if (term_hit) begin
            t_type = TypeT;
        end
    end

endmodule

// File: rtl/tx_encoder.sv
// Transmit 64B/66B encoder: classifies each enabled MII word, runs the
// transmit state machine and registers a 66-bit coded block for the scrambler.
// Ports:
//   i_clock     in  1   rising-edge clock
//   i_reset     in  1   asynchronous active-high reset
//   i_enable    in  1   input sample qualifier
//   i_tx_data   in  64  MII data, byte 0 in [63:56]
//   i_tx_ctrl   in  8   MII control mask, bit 7 = byte 0
//   o_tx_coded  out 66  sync header [65:64] + payload
//   o_valid     out 1   high the cycle after each enabled sample
//   o_err_count out 16  saturating count of emitted EBLOCK_T blocks
module tx_encoder
    import pcs_tx_pkg::*;
(
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic [LEN_TX_DATA-1:0]     i_tx_data,
    input  logic [LEN_TX_CTRL-1:0]     i_tx_ctrl,
    output logic [LEN_CODED_BLOCK-1:0] o_tx_coded,
    output logic                       o_valid,
    output logic [LEN_ERR_CNT-1:0]     o_err_count
);

    t_type_e    t_type;
    logic [2:0] term_lane;
    logic       ordered_set;

    tx_type_classifier u_classifier (
        .tx_data     (i_tx_data),
        .tx_ctrl     (i_tx_ctrl),
        .t_type      (t_type),
        .term_lane   (term_lane),
        .ordered_set (ordered_set)
    );

    tx_state_e                  state_q, state_d;
    logic [LEN_CODED_BLOCK-1:0] coded_q, coded_d;
    logic                       valid_q;
    logic [LEN_ERR_CNT-1:0]     err_q;
    logic [LEN_CODED_BLOCK-1:0] enc_block;
    logic [55:0]                ctrl_codes;
    logic [55:0]                term_mask;
    logic                       emit_err;

    // Block encoding mux, independent of state
    always_comb begin
        ctrl_codes = '0;
        for (int i = 0; i < 8; i++) begin
            ctrl_codes[55 - 7*i -: 7] = (i_tx_data[63 - 8*i -: 8] == MII_ERROR) ?
                                        CODE_ERROR : CODE_IDLE;
        end
        // Keep data lanes ahead of the terminate, zero the rest
        term_mask = ~({56{1'b1}} >> {term_lane, 3'b000});

        unique case (t_type)
            TypeD: enc_block = {SH_DATA, i_tx_data};
            TypeS: enc_block = {SH_CTRL, BT_START, i_tx_data[55:0]};
            TypeC: begin
                if (ordered_set) begin
                    enc_block = {SH_CTRL, BT_OSET, i_tx_data[55:32], 4'h0, 28'h0};
                end else begin
                    enc_block = {SH_CTRL, BT_CTRL, ctrl_codes};
                end
            end
            TypeT: enc_block = {SH_CTRL, term_block_type(term_lane),
                                i_tx_data[63:8] & term_mask};
            default: enc_block = EBLOCK_T;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        emit_err = 1'b0;
        unique case (state_q)
            TxD: begin
                if (t_type == TypeD) begin
                    state_d = TxD;
                end else if (t_type == TypeT) begin
                    state_d = TxT;
                end else begin
                    state_d  = TxE;
                    emit_err = 1'b1;
                end
            end
            TxE: begin
                unique case (t_type)
                    TypeD, TypeS: state_d = TxD;
                    TypeC:        state_d = TxC;
                    TypeT:        state_d = TxT;
                    default: begin
                        state_d  = TxE;
                        emit_err = 1'b1;
                    end
                endcase
            end
            // TxInit, TxC and TxT share the same transitions
            default: begin
                if (t_type == TypeC) begin
                    state_d = TxC;
                end else if (t_type == TypeS) begin
                    state_d = TxD;
                end else begin
                    state_d  = TxE;
                    emit_err = 1'b1;
                end
            end
        endcase
        coded_d = emit_err ? EBLOCK_T : enc_block;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= TxInit;
            coded_q <= LBLOCK_T;
            valid_q <= 1'b0;
            err_q   <= '0;
        end else begin
            valid_q <= i_enable;
            if (i_enable) begin
                state_q <= state_d;
                coded_q <= coded_d;
                if (emit_err && (err_q != '1)) begin
                    err_q <= err_q + 1'b1;
                end
            end
        end
    end

    assign o_tx_coded  = coded_q;
    assign o_valid     = valid_q;
    assign o_err_count = err_q;

endmodule

// File: tb/tb_tx_encoder.sv
// Directed self-checking bench for tx_encoder.
module tb_tx_encoder;

    localparam logic [65:0] EBLK = 66'h2_1E3C_78F1_E3C7_8F1E;
    localparam logic [65:0] LBLK = 66'h2_4B00_0001_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [63:0] tx_data;
    logic [7:0]  tx_ctrl;
    logic [65:0] tx_coded;
    logic        valid;
    logic [15:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;

    tx_encoder dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_enable    (en),
        .i_tx_data   (tx_data),
        .i_tx_ctrl   (tx_ctrl),
        .o_tx_coded  (tx_coded),
        .o_valid     (valid),
        .o_err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one enabled word and sample 1 time unit after the capturing edge
    task automatic send(input logic [63:0] d, input logic [7:0] c);
        tx_data = d;
        tx_ctrl = c;
        en      = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_blk(input string tag, input logic [65:0] blk, input logic [15:0] errs);
        check_eq({tag, ".coded"}, tx_coded, blk);
        check_eq({tag, ".valid"}, 66'(valid), 66'd1);
        check_eq({tag, ".errs"}, 66'(err_count), 66'(errs));
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        tx_data = '0;
        tx_ctrl = '0;
        #2;
        check_eq("rst.coded", tx_coded, LBLK);
        check_eq("rst.valid", 66'(valid), 66'd0);
        check_eq("rst.errs", 66'(err_count), 66'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        send(64'h0707070707070707, 8'hFF);
        expect_blk("idle", 66'h2_1E00_0000_0000_0000, 16'd0);
        send(64'hFB55555555555555, 8'h80);
        expect_blk("start", 66'h2_7855_5555_5555_5555, 16'd0);
        send(64'h0011223344556677, 8'h00);
        expect_blk("data", 66'h1_0011_2233_4455_6677, 16'd0);
        send(64'hAABBCCFD07070707, 8'h1F);
        expect_blk("term3", 66'h2_B4AA_BBCC_0000_0000, 16'd0);
        send(64'h0707070707070707, 8'hFF);
        expect_blk("idle_after_t", 66'h2_1E00_0000_0000_0000, 16'd0);

        // Data while idling is an error; idle recovers
        send(64'h0123456789ABCDEF, 8'h00);
        expect_blk("data_in_c", EBLK, 16'd1);
        send(64'h0707070707070707, 8'hFF);
        expect_blk("idle_from_e", 66'h2_1E00_0000_0000_0000, 16'd1);

        // Start inside a packet is an error; data then resumes
        send(64'hFB55555555555555, 8'h80);
        expect_blk("start2", 66'h2_7855_5555_5555_5555, 16'd1);
        send(64'h0011223344556677, 8'h00);
        expect_blk("data2", 66'h1_0011_2233_4455_6677, 16'd1);
        send(64'hFB55555555555555, 8'h80);
        expect_blk("start_in_d", EBLK, 16'd2);
        send(64'h0011223344556677, 8'h00);
        expect_blk("data_from_e", 66'h1_0011_2233_4455_6677, 16'd2);
        send(64'h11223344556677FD, 8'h01);
        expect_blk("term7", 66'h2_FF11_2233_4455_6677, 16'd2);

        send(64'h9C00000107070707, 8'h8F);
        expect_blk("oset", 66'h2_4B00_0001_0000_0000, 16'd2);
        send(64'hFE07070707070707, 8'hFF);
        expect_blk("idle_err", 66'h2_1E3C_0000_0000_0000, 16'd2);

        // Enable low: everything holds, valid drops
        en      = 1'b0;
        tx_data = 64'h0011223344556677;
        tx_ctrl = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq("hold.coded", tx_coded, 66'h2_1E3C_0000_0000_0000);
            check_eq("hold.valid", 66'(valid), 66'd0);
            check_eq("hold.errs", 66'(err_count), 66'd2);
        end

        // Unclassifiable words
        send(64'h0000000000000000, 8'h01);
        expect_blk("etype_in_c", EBLK, 16'd3);
        send(64'h0000000000000000, 8'h01);
        expect_blk("etype_in_e", EBLK, 16'd4);
        send(64'hFD07070707070707, 8'hFF);
        expect_blk("term0_from_e", 66'h2_8700_0000_0000_0000, 16'd4);
        send(64'hFB55555555555555, 8'h80);
        expect_blk("start3", 66'h2_7855_5555_5555_5555, 16'd4);
        send(64'h0011223344556677, 8'h00);
        expect_blk("data3", 66'h1_0011_2233_4455_6677, 16'd4);

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst.coded", tx_coded, LBLK);
        check_eq("arst.valid", 66'(valid), 66'd0);
        check_eq("arst.errs", 66'(err_count), 66'd0);
        #1;
        rst = 1'b0;
        send(64'h0011223344556677, 8'h00);
        expect_blk("data_after_rst", EBLK, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
